// File: rtl/gdl_trigger_sequencer_pkg.sv
// Shared types and constants for the GDL trigger sequencer.
// FTD bit indices name the physics channels feeding the sequencer.
package gdl_pkg;
    localparam int NBIT = 13;

    localparam int ZZX        = 0;
    localparam int FFS        = 1;
    localparam int ZX         = 2;
    localparam int FS         = 3;
    localparam int HIE        = 4;
    localparam int C4         = 5;
    localparam int BHABHA     = 6;
    localparam int BHABHA_TRK = 7;
    localparam int GG         = 8;
    localparam int MU_PAIR    = 9;
    localparam int REVOLUTION = 10;
    localparam int RANDOM     = 11;
    localparam int BG         = 12;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DEAD
    } state_t;
endpackage

// File: rtl/gdl_trigger_sequencer_if.sv
// DAQ trigger handshake between the sequencer (master) and DAQ (slave).
// The sequencer holds trg_req, psnm and trg_type until acknowledged.
interface gdl_trigger_sequencer_if;
    import gdl_pkg::*;

    logic            daq_busy;
    logic            trg_req;
    logic            trg_ack;
    logic [3:0]      trg_type;
    logic [NBIT-1:0] psnm;

    modport master (
        input  daq_busy,
        input  trg_ack,
        output trg_req,
        output trg_type,
        output psnm
    );

    modport slave (
        output daq_busy,
        output trg_ack,
        input  trg_req,
        input  trg_type,
        input  psnm
    );
endinterface

// File: rtl/gdl_trigger_sequencer_prescaler.sv
// Per-bit prescaler: fires on every Nth input firing, N=0 disables.
// A config write to this bit reloads N and restarts the count.
module gdl_prescaler #(
    parameter int PSW = 8,
    parameter int AW  = 4,
    parameter int IDX = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ftd,
    input  logic           cfg_we,
    input  logic [AW-1:0]  cfg_addr,
    input  logic [PSW-1:0] cfg_data,
    output logic           hit
);
    logic [PSW-1:0] ps;
    logic [PSW-1:0] cnt;
    logic           sel;
    logic           fire;

    assign sel  = cfg_we && (cfg_addr == AW'(IDX));
    assign fire = ftd && (ps != '0);
    assign hit  = fire && (cnt == ps - PSW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps  <= PSW'(1);
            cnt <= '0;
        end else if (sel) begin
            ps  <= cfg_data;
            cnt <= '0;
        end else if (fire) begin
            cnt <= hit ? '0 : cnt + PSW'(1);
        end
    end
endmodule

// File: rtl/gdl_trigger_sequencer.sv
// GDL final trigger sequencer: prescale FTD bits, issue one L1 request
// at a time to DAQ, enforce deadtime, count issued and lost triggers.
module gdl_trigger_sequencer #(
    parameter int NBIT     = 13,
    parameter int PSW      = 8,
    parameter int AW       = 4,
    parameter int DEADTIME = 4,
    parameter int CNTW     = 32
) (
    input  logic                     gclk2,
    input  logic                     rst_n,
    input  logic [NBIT-1:0]          ftd_in,
    input  logic                     cfg_we,
    input  logic [AW-1:0]            cfg_addr,
    input  logic [PSW-1:0]           cfg_data,
    gdl_trigger_sequencer_if.master  daq,
    output logic [CNTW-1:0]          trg_cnt,
    output logic [15:0]              lost_cnt
);
    import gdl_pkg::*;

    localparam int DW = (DEADTIME > 1) ? $clog2(DEADTIME + 1) : 1;

    state_t          state;
    state_t          state_nx;
    logic [DW-1:0]   dcnt;
    logic [DW-1:0]   dcnt_nx;
    logic [NBIT-1:0] hit;
    logic            any_hit;
    logic            issue;
    logic            ack_ok;
    logic [3:0]      prio;

    for (genvar gi = 0; gi < NBIT; gi++) begin : g_ps
        gdl_prescaler #(
            .PSW (PSW),
            .AW  (AW),
            .IDX (gi)
        ) u_ps (
            .clk      (gclk2),
            .rst_n    (rst_n),
            .ftd      (ftd_in[gi]),
            .cfg_we   (cfg_we),
            .cfg_addr (cfg_addr),
            .cfg_data (cfg_data),
            .hit      (hit[gi])
        );
    end

    assign any_hit = |hit;

    // Scan downward so the lowest set bit is the last to be written.
    always_comb begin
        prio = '0;
        for (int i = NBIT - 1; i >= 0; i--) begin
            if (hit[i]) prio = 4'(i);
        end
    end

    always_comb begin
        state_nx = state;
        dcnt_nx  = dcnt;
        issue    = 1'b0;
        ack_ok   = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_hit && !daq.daq_busy) begin
                    issue    = 1'b1;
                    state_nx = REQ;
                end
            end
            REQ: begin
                if (daq.trg_ack) begin
                    ack_ok = 1'b1;
                    if (DEADTIME == 0) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx = DEAD;
                        dcnt_nx  = DW'(DEADTIME);
                    end
                end
            end
            DEAD: begin
                if (dcnt == DW'(1)) state_nx = IDLE;
                else                dcnt_nx  = dcnt - DW'(1);
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge gclk2 or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            dcnt         <= '0;
            daq.psnm     <= '0;
            daq.trg_type <= '0;
            trg_cnt      <= '0;
            lost_cnt     <= '0;
        end else begin
            state <= state_nx;
            dcnt  <= dcnt_nx;
            if (issue) begin
                daq.psnm     <= hit;
                daq.trg_type <= prio;
            end
            if (ack_ok) trg_cnt <= trg_cnt + CNTW'(1);
            if (any_hit && !issue && lost_cnt != 16'hFFFF)
                lost_cnt <= lost_cnt + 16'd1;
        end
    end

    assign daq.trg_req = (state == REQ);
endmodule
